// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states in front of a doubleword-organised backing array.
module dmem_responder #(
  parameter int          DEPTH   = 256,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_strb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic [63:0] r_wdata;
  logic [7:0]  r_strb;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_do_access;
  logic [63:0]   w_addr;
  logic          w_write;
  logic [1:0]    w_size;
  logic [63:0]   w_wdata;
  logic [7:0]    w_strb;
  logic [63:0]   w_off;
  logic          w_range;
  logic          w_misalign;
  logic          w_fault;
  logic [AW-1:0] w_idx;

  assign o_req_ready  = (r_state == S_IDLE) && !rst;
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;
  assign o_busy       = (r_state != S_IDLE);

  assign w_accept = i_req_valid && o_req_ready;

  // Zero-latency accesses use the live request in the accept cycle.
  assign w_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
  assign w_write = (r_state == S_IDLE) ? i_req_write : r_write;
  assign w_size  = (r_state == S_IDLE) ? i_req_size  : r_size;
  assign w_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
  assign w_strb  = (r_state == S_IDLE) ? i_req_strb  : r_strb;

  assign w_do_access = (r_state == S_IDLE) ? (w_accept && (LATENCY == 0))
                                           : ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_off   = w_addr - BASE;
  assign w_range = (w_addr >= BASE) && (w_off < SPAN);
  assign w_idx   = w_off[AW+2:3];

  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      2'b01:   w_misalign = w_addr[0];
      2'b10:   w_misalign = (w_addr[1:0] != 2'b00);
      2'b11:   w_misalign = (w_addr[2:0] != 3'b000);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_fault = !w_range || w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= i_req_addr;
            r_write <= i_req_write;
            r_size  <= i_req_size;
            r_wdata <= i_req_wdata;
            r_strb  <= i_req_strb;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= LAT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response word is only loaded at the transition into RESP, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_do_access) begin
      r_rdata <= (w_fault || w_write) ? 64'd0 : r_mem[w_idx];
      r_err   <= w_fault;
    end else if (o_resp_valid && i_resp_ready) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_access && w_write && !w_fault) begin
      for (int b = 0; b < 8; b++) begin
        if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: main instance at LATENCY=2, plus
// LATENCY=0 and LATENCY=4 instances for the latency and mid-WAIT reset cases.
module tb_dmem_responder;
  localparam int          DEPTH = 256;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT   = 2;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, rst4;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic [1:0]  req_size;
  logic [7:0]  req_strb;

  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err, z_busy;
  logic [63:0] z_req_addr, z_req_wdata, z_resp_rdata;
  logic [1:0]  z_req_size;
  logic [7:0]  z_req_strb;

  logic        f_req_valid, f_req_ready, f_req_write, f_resp_valid, f_resp_ready, f_resp_err, f_busy;
  logic [63:0] f_req_addr, f_req_wdata, f_resp_rdata;
  logic [1:0]  f_req_size;
  logic [7:0]  f_req_strb;

  dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_write(req_write), .i_req_size(req_size), .i_req_wdata(req_wdata),
    .i_req_strb(req_strb), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .i_req_valid(z_req_valid), .o_req_ready(z_req_ready), .i_req_addr(z_req_addr),
    .i_req_write(z_req_write), .i_req_size(z_req_size), .i_req_wdata(z_req_wdata),
    .i_req_strb(z_req_strb), .o_resp_valid(z_resp_valid), .i_resp_ready(z_resp_ready),
    .o_resp_rdata(z_resp_rdata), .o_resp_err(z_resp_err), .o_busy(z_busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .i_req_valid(f_req_valid), .o_req_ready(f_req_ready), .i_req_addr(f_req_addr),
    .i_req_write(f_req_write), .i_req_size(f_req_size), .i_req_wdata(f_req_wdata),
    .i_req_strb(f_req_strb), .o_resp_valid(f_resp_valid), .i_resp_ready(f_resp_ready),
    .o_resp_rdata(f_resp_rdata), .o_resp_err(f_resp_err), .o_busy(f_busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [63:0] mdl [DEPTH];
  int          last_acc = 0;
  int          hs_cyc   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference behaviour of one access; updates the model array on good stores.
  function automatic exp_t model(input logic [63:0] a, input logic w, input logic [1:0] sz,
                                 input logic [63:0] wd, input logic [7:0] st);
    exp_t        e;
    logic [63:0] off;
    logic        bad;
    int          idx;
    off = a - BASE;
    bad = (a < BASE) || (off >= 64'(DEPTH * 8));
    if (sz == 2'b01 && a[0] != 1'b0)     bad = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00)  bad = 1'b1;
    if (sz == 2'b11 && a[2:0] != 3'b000) bad = 1'b1;
    e.rdata = 64'd0;
    e.err   = bad;
    e.cyc   = 0;
    if (!bad) begin
      idx = int'(off >> 3);
      if (w) begin
        for (int i = 0; i < 8; i++) if (st[i]) mdl[idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.rdata = mdl[idx];
      end
    end
    return e;
  endfunction

  task automatic req(input logic [63:0] a, input logic w, input logic [1:0] sz,
                     input logic [63:0] wd, input logic [7:0] st);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz; req_wdata = wd; req_strb = st;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accepted", req_ready, 1);
    if (req_ready) begin
      e = model(a, w, sz, wd, st);
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
      last_acc = cyc;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_write = ~w;
    req_strb  = 8'($urandom);
    req_size  = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  logic        m_prev_v, m_prev_hs, m_prev_err;
  logic [63:0] m_prev_rdata;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_prev_v  <= 1'b0;
      m_prev_hs <= 1'b0;
    end else begin
      if (resp_valid) begin
        check("ready_low_in_resp", req_ready, 0);
        check("busy_in_resp", busy, 1);
        if (!m_prev_v || m_prev_hs) begin
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) check("resp_cycle", cyc, sb[0].cyc);
        end else begin
          check("stall_rdata", resp_rdata, m_prev_rdata);
          check("stall_err", resp_err, m_prev_err);
        end
        if (resp_ready && sb.size() != 0) begin
          m_e = sb.pop_front();
          check("resp_rdata", resp_rdata, m_e.rdata);
          check("resp_err", resp_err, m_e.err);
          hs_cyc <= cyc;
        end
      end
      m_prev_v     <= resp_valid;
      m_prev_hs    <= resp_valid && resp_ready;
      m_prev_rdata <= resp_rdata;
      m_prev_err   <= resp_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [63:0] a;
    int          off;
    rst = 1'b1; rst4 = 1'b1;
    req_valid = 0; req_addr = 0; req_write = 0; req_size = 0; req_wdata = 0; req_strb = 0;
    z_req_valid = 0; z_req_addr = 0; z_req_write = 0; z_req_size = 0; z_req_wdata = 0; z_req_strb = 0;
    f_req_valid = 0; f_req_addr = 0; f_req_write = 0; f_req_size = 0; f_req_wdata = 0; f_req_strb = 0;
    resp_ready = 1'b1; z_resp_ready = 1'b1; f_resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 64'd0;

    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    check("idle_valid", resp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_rdata", resp_rdata, 0);
    check("idle_err", resp_err, 0);

    req(BASE, 0, 2'b11, 0, 8'h00);
    req(BASE + 8, 1, 2'b11, 64'h1122334455667788, 8'hFF);
    req(BASE + 8, 0, 2'b11, 0, 8'h00);
    req(BASE + 8, 1, 2'b11, '1, 8'hFF);
    req(BASE + 64'hD, 1, 2'b00, {8{8'hAB}}, 8'h20);
    req(BASE + 8, 0, 2'b11, 0, 8'h00);
    req(BASE - 8, 0, 2'b11, 0, 8'h00);
    req(BASE + 2, 0, 2'b10, 0, 8'h00);
    req(BASE + 1, 0, 2'b01, 0, 8'h00);
    req(BASE + 4, 0, 2'b11, 0, 8'h00);
    req(BASE + 4, 0, 2'b10, 0, 8'h00);
    req(BASE + 6, 0, 2'b01, 0, 8'h00);
    req(BASE + 64'((DEPTH - 1) * 8), 1, 2'b11, 64'hDEADBEEF0BADF00D, 8'hFF);
    req(BASE + 64'(DEPTH * 8), 1, 2'b11, '1, 8'hFF);
    req(BASE + 64'((DEPTH - 1) * 8), 0, 2'b11, 0, 8'h00);
    req(BASE + 8, 1, 2'b11, 64'h0, 8'h00);
    req(BASE + 8, 0, 2'b11, 0, 8'h00);

    for (int k = 0; k < 24; k++) begin
      off = int'($urandom_range(0, 47));
      a = ($urandom_range(0, 7) == 0) ? BASE + 64'(DEPTH * 8) + 64'(off) : BASE + 64'(off);
      req(a, 1'($urandom), 2'($urandom), {$urandom, $urandom}, 8'($urandom));
    end
    drain();

    // Backpressure: stall the response, hold the next request pending meanwhile.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req(BASE + 8, 0, 2'b11, 0, 8'h00);
    fork
      req(BASE + 64'hD, 0, 2'b00, 0, 8'h00);
      begin
        n = 0;
        while (!resp_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        resp_ready = 1'b1;
      end
    join
    check("accept_after_hs", last_acc, hs_cyc + 1);
    drain();

    // LATENCY=0 instance
    @(posedge clk); #1;
    z_req_valid = 1; z_req_addr = BASE + 16; z_req_write = 1; z_req_size = 2'b11;
    z_req_wdata = 64'hCAFEF00D12345678; z_req_strb = 8'hFF;
    @(negedge clk);
    check("z_accept_st", z_req_ready, 1);
    @(posedge clk); #1;
    z_req_valid = 0; z_req_addr = '1; z_req_wdata = 0; z_req_strb = 0;
    @(negedge clk);
    check("z_st_valid_c1", z_resp_valid, 1);
    check("z_st_rdata", z_resp_rdata, 0);
    check("z_st_err", z_resp_err, 0);
    @(posedge clk); #1;
    z_req_valid = 1; z_req_addr = BASE + 16; z_req_write = 0;
    @(negedge clk);
    check("z_accept_ld", z_req_ready, 1);
    @(posedge clk); #1;
    z_req_valid = 0; z_req_addr = '1;
    @(negedge clk);
    check("z_ld_valid_c1", z_resp_valid, 1);
    check("z_ld_rdata", z_resp_rdata, 64'hCAFEF00D12345678);
    check("z_ld_err", z_resp_err, 0);

    // LATENCY=4 instance: reset during WAIT on a store
    @(posedge clk); #1;
    f_req_valid = 1; f_req_addr = BASE; f_req_write = 1; f_req_size = 2'b11;
    f_req_wdata = 64'h5555AAAA5555AAAA; f_req_strb = 8'hFF;
    @(negedge clk);
    check("f_accept_st", f_req_ready, 1);
    @(posedge clk); #1;
    f_req_valid = 0;
    @(negedge clk);
    check("f_busy_wait", f_busy, 1);
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(negedge clk);
    check("f_rst_ready", f_req_ready, 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(negedge clk);
    check("f_post_ready", f_req_ready, 1);
    check("f_post_valid", f_resp_valid, 0);
    check("f_post_busy", f_busy, 0);
    check("f_post_rdata", f_resp_rdata, 0);
    check("f_post_err", f_resp_err, 0);
    repeat (6) begin
      @(negedge clk);
      check("f_no_stale_resp", f_resp_valid, 0);
    end
    @(posedge clk); #1;
    f_req_valid = 1; f_req_write = 0; f_req_addr = BASE;
    @(negedge clk);
    check("f_accept_ld", f_req_ready, 1);
    @(posedge clk); #1;
    f_req_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("f_ld_valid_timing", f_resp_valid, (k == 5) ? 1 : 0);
    end
    check("f_ld_rdata", f_resp_rdata, 0);
    check("f_ld_err", f_resp_err, 0);

    check("sb_final_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
